// File: rtl/fb_scanout_pkg.sv
// Shared types and raster-timing helpers for the frame-buffer scanout.
// The 12-bit coordinate type is also used by the rasterizer.
package fb_scanout_pkg;

    typedef logic [11:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp,
                                    input int sync);
        return active + fp + sync;
    endfunction

    function automatic int span_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = span_total(H_ACTIVE_DEF, H_FP_DEF,
                                        H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL = span_total(V_ACTIVE_DEF, V_FP_DEF,
                                        V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/fb_scanout_timing_gen.sv
// Pixel-tick divider and horizontal/vertical raster counters.
// Counters sit at zero whenever run_i is low.
module fb_timing_gen
    import fb_scanout_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   run_i,
    output logic   tick_o,
    output coord_t h_cnt_o,
    output coord_t v_cnt_o,
    output logic   act_o,
    output logic   hs_on_o,
    output logic   vs_on_o,
    output logic   origin_o,
    output logic   last_o
);

    localparam coord_t H_LAST   = coord_t'(span_total(H_ACTIVE, H_FP,
                                                      H_SYNC, H_BP) - 1);
    localparam coord_t V_LAST   = coord_t'(span_total(V_ACTIVE, V_FP,
                                                      V_SYNC, V_BP) - 1);
    localparam coord_t HS_START = coord_t'(sync_start(H_ACTIVE, H_FP));
    localparam coord_t HS_END   = coord_t'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam coord_t VS_START = coord_t'(sync_start(V_ACTIVE, V_FP));
    localparam coord_t VS_END   = coord_t'(sync_end(V_ACTIVE, V_FP, V_SYNC));
    localparam coord_t DIV_LAST = coord_t'(CLK_DIV - 1);

    coord_t div_q, div_d;
    coord_t h_q, h_d;
    coord_t v_q, v_d;

    assign tick_o = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (!run_i) begin
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
        end else if (tick_o) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign h_cnt_o  = h_q;
    assign v_cnt_o  = v_q;
    assign act_o    = (h_q < coord_t'(H_ACTIVE)) && (v_q < coord_t'(V_ACTIVE));
    assign hs_on_o  = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_on_o  = (v_q >= VS_START) && (v_q < VS_END);
    assign origin_o = (h_q == '0) && (v_q == '0);
    assign last_o   = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/fb_scanout.sv
// Raster-order reader of the 1-bit video memory with VGA-style syncs.
// FB_SCANOUT_TEST_PATTERN_EN adds pattern_sel for a 32x32 checkerboard.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    output logic [11:0] rd_row,
    output logic [11:0] rd_col,
    input  logic        rd_data,
    output logic        pixel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        busy
);

    state_e state_q, state_d;
    logic   tick, act, hs_on, vs_on, origin, last;
    coord_t h_cnt, v_cnt;
    logic   src;
    logic   px_q, px_d;
    logic   de_q, de_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;
    logic   fs_q, fs_d;

    fb_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .clk_i    (clk),
        .rst_i    (rst),
        .run_i    (state_q != IDLE),
        .tick_o   (tick),
        .h_cnt_o  (h_cnt),
        .v_cnt_o  (v_cnt),
        .act_o    (act),
        .hs_on_o  (hs_on),
        .vs_on_o  (vs_on),
        .origin_o (origin),
        .last_o   (last)
    );

    assign rd_row = (v_cnt < coord_t'(V_ACTIVE)) ? v_cnt : '0;
    assign rd_col = (h_cnt < coord_t'(H_ACTIVE)) ? h_cnt : '0;

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    logic pat_q, pat_d;

    // Sampled only at frame boundaries so a frame is never mixed.
    always_comb begin
        pat_d = pat_q;
        if ((state_q == IDLE) || (tick && last)) begin
            pat_d = pattern_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= 1'b0;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign src = pat_q ? (rd_row[5] ^ rd_col[5]) : rd_data;
`else
    assign src = rd_data;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (tick && last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        px_d = px_q;
        de_d = de_q;
        hs_d = hs_q;
        vs_d = vs_q;
        fs_d = 1'b0;
        if (state_q == IDLE) begin
            px_d = 1'b0;
            de_d = 1'b0;
            hs_d = 1'b1;
            vs_d = 1'b1;
        end else if (tick) begin
            px_d = act & src;
            de_d = act;
            hs_d = ~hs_on;
            vs_d = ~vs_on;
            fs_d = origin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            px_q    <= 1'b0;
            de_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
        end
    end

    assign pixel       = px_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: two shrunk-raster instances (CLK_DIV 2 and 1)
// compared every clk against a frame-position reference model.
module tb_fb_scanout;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [29:0] IDLE_V = {6'b000110, 24'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, en0, en1, rdd0, rdd1;
    logic [11:0] row0, col0, row1, col1;
    logic px0, de0, hs0, vs0, fs0, busy0;
    logic px1, de1, hs1, vs1, fs1, busy1;
    logic mem [VA][HA];

    assign rdd0 = (row0 < 12'(VA) && col0 < 12'(HA)) ? mem[row0[3:0]][col0[3:0]] : 1'b0;
    assign rdd1 = (row1 < 12'(VA) && col1 < 12'(HA)) ? mem[row1[3:0]][col1[3:0]] : 1'b0;

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CLK_DIV(2)
    ) u_dut0 (
        .clk(clk), .rst(rst0), .enable(en0),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .rd_row(row0), .rd_col(col0), .rd_data(rdd0),
        .pixel(px0), .de(de0), .hsync(hs0), .vsync(vs0),
        .frame_start(fs0), .busy(busy0)
    );

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CLK_DIV(1)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .enable(en1),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .rd_row(row1), .rd_col(col1), .rd_data(rdd1),
        .pixel(px1), .de(de1), .hsync(hs1), .vsync(vs1),
        .frame_start(fs1), .busy(busy1)
    );

    wire [29:0] obs0 = {busy0, fs0, de0, hs0, vs0, px0, row0, col0};
    wire [29:0] obs1 = {busy1, fs1, de1, hs1, vs1, px1, row1, col1};

    int n_assert = 0;
    int n_fail = 0;
    int ms[2];
    int mn[2];
    logic [29:0] ev[2];
    bit meas = 0;
    int m_cyc, m_de, m_hs, m_vs;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // ms: 0 idle, 1 run, 2 drain; mn counts clk edges since RUN entry
    task automatic model_edge(input int d, input bit r, input bit en);
        int dv, k, p, h, v, t;
        bit tick, ef;
        logic b, f, dd, hh, vv, pp;
        logic [11:0] rr, cc;
        dv = (d == 0) ? 2 : 1;
        {b, f, dd, hh, vv, pp, rr, cc} = ev[d];
        if (r) begin
            ms[d] = 0;
            mn[d] = 0;
            {f, dd, hh, vv, pp} = 5'b00110;
        end else if (ms[d] == 0) begin
            {f, dd, hh, vv, pp} = 5'b00110;
            if (en) begin
                ms[d] = 1;
                mn[d] = 0;
            end
        end else begin
            mn[d]++;
            tick = (mn[d] % dv) == 0;
            ef = 0;
            f = 0;
            if (tick) begin
                k = mn[d] / dv - 1;
                p = k % FRAME;
                h = p % HT;
                v = p / HT;
                dd = (h < HA) && (v < VA);
                pp = dd ? mem[v][h] : 1'b0;
                hh = !(h >= HA + HFP && h < HA + HFP + HS);
                vv = !(v >= VA + VFP && v < VA + VFP + VS);
                f = (p == 0);
                ef = (p == FRAME - 1);
            end
            if (ms[d] == 1) begin
                if (!en) ms[d] = 2;
            end else begin
                if (en) ms[d] = 1;
                else if (tick && ef) ms[d] = 0;
            end
        end
        b = (ms[d] != 0);
        rr = '0;
        cc = '0;
        if (ms[d] != 0) begin
            t = mn[d] / dv;
            p = t % FRAME;
            h = p % HT;
            v = p / HT;
            rr = (v < VA) ? 12'(v) : 12'd0;
            cc = (h < HA) ? 12'(h) : 12'd0;
        end
        ev[d] = {b, f, dd, hh, vv, pp, rr, cc};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge(0, rst0, en0);
        model_edge(1, rst1, en1);
        chk("dut0_cycle", 32'(obs0), 32'(ev[0]));
        chk("dut1_cycle", 32'(obs1), 32'(ev[1]));
        if (meas) begin
            m_cyc++;
            if (de0) m_de++;
            if (!hs0) m_hs++;
            if (!vs0) m_vs++;
        end
    endtask

    task automatic wait_fs0(input int bound, output bit got);
        got = 0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            if (fs0) got = 1;
        end
    endtask

    initial begin
        bit got;
        rst0 = 1; rst1 = 1; en0 = 0; en1 = 0;
        for (int r = 0; r < VA; r++)
            for (int c = 0; c < HA; c++)
                mem[r][c] = 1'((r + c) & 1) ^ ($urandom_range(0, 3) == 0);
        mem[5][7] = 1'b1;
        mem[6][7] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ms[d] = 0; mn[d] = 0; ev[d] = IDLE_V;
        end

        repeat (20) step();
        chk("reset_idle0", 32'(obs0), 32'(IDLE_V));
        rst0 = 0; rst1 = 0;
        repeat (10) step();

        en0 = 1; en1 = 1;
        wait_fs0(3 * FRAME * 2, got);
        chk("fs0_first", 32'(got), 32'd1);
        m_cyc = 0; m_de = 0; m_hs = 0; m_vs = 0;
        meas = 1;
        wait_fs0(3 * FRAME * 2, got);
        meas = 0;
        chk("fs0_second", 32'(got), 32'd1);
        chk("frame_period", 32'(m_cyc), 32'(FRAME * 2));
        chk("de_clks", 32'(m_de), 32'(HA * VA * 2));
        chk("hs_low_clks", 32'(m_hs), 32'(HS * 2 * VT));
        chk("vs_low_clks", 32'(m_vs), 32'(VS * HT * 2));

        repeat (FRAME * 2 / 3) step();
        en0 = 0;
        repeat (200) step();
        en0 = 1;
        repeat (3) step();
        en0 = 0;
        got = 0;
        for (int i = 0; i < 2 * FRAME * 2 && !got; i++) begin
            step();
            if (!busy0) got = 1;
        end
        chk("drain_to_idle", 32'(got), 32'd1);
        repeat (20) step();
        chk("idle_after_drain", 32'(obs0), 32'(IDLE_V));

        got = 0;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            step();
            if (ms[1] != 0 && (mn[1] % FRAME) == 6 * HT + 8) got = 1;
        end
        chk("dut1_reach_mid", 32'(got), 32'd1);
        chk("dut1_running", 32'(busy1), 32'd1);
        #2 rst1 = 1;
        #1 chk("dut1_async_rst", 32'(obs1), 32'(IDLE_V));
        en1 = 0;
        ms[1] = 0; mn[1] = 0; ev[1] = IDLE_V;
        repeat (2) step();
        rst1 = 0;
        step();
        en1 = 1;
        step();
        chk("dut1_entry_busy", 32'(busy1), 32'd1);
        chk("dut1_entry_nofs", 32'(fs1), 32'd0);
        step();
        chk("dut1_fs_after_entry", 32'(fs1), 32'd1);
        step();
        chk("dut1_fs_pulse_end", 32'(fs1), 32'd0);
        repeat (FRAME + 50) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
